// File: rtl/jac_status_pkg.sv
// Shared definitions for the status register: default width, flag positions,
// reset value and the stack-operation encoding used by the top level.
package jac_status_pkg;

    localparam int NUM_STATUS_BITS_DEF = 3;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;

    localparam logic [31:0] STATUS_RST = 32'd0;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } stack_op_e;

endpackage

// File: rtl/status_lifo.sv
// Save stack for the status word. Callers pass only qualified push/pop
// requests; this block just stores, counts and reports occupancy.
module status_lifo #(
    parameter int Width  = 3,
    parameter int Depth  = 4,
    parameter int DepthW = $clog2(Depth + 1)
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              push_en,
    input  logic              pop_en,
    input  logic [Width-1:0]  wr_data,
    output logic [Width-1:0]  rd_data,
    output logic [DepthW-1:0] depth,
    output logic              full,
    output logic              empty
);

    logic [Width-1:0]  r_mem [Depth];
    logic [DepthW-1:0] r_depth;
    logic [Width-1:0]  w_top;

    // Entry storage and occupancy counter.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_depth <= {DepthW{1'b0}};
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= {Width{1'b0}};
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (push_en && (r_depth == DepthW'(i))) begin
                    r_mem[i] <= wr_data;
                end else begin
                    r_mem[i] <= r_mem[i];
                end
            end
            if (push_en) begin
                r_depth <= r_depth + DepthW'(1);
            end else if (pop_en) begin
                r_depth <= r_depth - DepthW'(1);
            end else begin
                r_depth <= r_depth;
            end
        end
    end

    // Top-of-stack select; zero when empty so no out-of-range index is formed.
    always_comb begin
        w_top = {Width{1'b0}};
        for (int i = 0; i < Depth; i++) begin
            if (r_depth == DepthW'(i + 1)) begin
                w_top = r_mem[i];
            end else begin
                w_top = w_top;
            end
        end
    end

    assign rd_data = w_top;
    assign depth   = r_depth;
    assign full    = (r_depth == DepthW'(Depth));
    assign empty   = (r_depth == {DepthW{1'b0}});

endmodule

// File: rtl/status_stack_reg.sv
// Processor status register with ALU/decoder masked writes, a LIFO save
// stack for interrupt/call context and sticky overflow/underflow flags.
module status_stack_reg
    import jac_status_pkg::*;
#(
    parameter int NumStatusBits = NUM_STATUS_BITS_DEF,
    parameter int StackDepth    = 4,
    parameter int DepthW        = $clog2(StackDepth + 1)
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     alu_wr_en,
    input  logic [NumStatusBits-1:0] alu_status,
    input  logic [NumStatusBits-1:0] alu_mask,
    input  logic                     dec_wr_en,
    input  logic [NumStatusBits-1:0] dec_status,
    input  logic [NumStatusBits-1:0] dec_mask,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     err_clr,
    output logic [NumStatusBits-1:0] status,
    output logic [DepthW-1:0]        depth,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    logic [NumStatusBits-1:0] r_status;
    logic                     r_ovf_err;
    logic                     r_unf_err;
    logic [NumStatusBits-1:0] w_top;
    logic [NumStatusBits-1:0] w_merged;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push_ok;
    logic                     w_pop_ok;
    logic                     w_ovf_evt;
    logic                     w_unf_evt;
    stack_op_e                w_op;

    // ALU has priority over the decoder on every bit both sources target.
    function automatic logic [NumStatusBits-1:0] merge_status(
        input logic [NumStatusBits-1:0] cur,
        input logic                     a_en,
        input logic [NumStatusBits-1:0] a_val,
        input logic [NumStatusBits-1:0] a_msk,
        input logic                     d_en,
        input logic [NumStatusBits-1:0] d_val,
        input logic [NumStatusBits-1:0] d_msk
    );
        logic [NumStatusBits-1:0] res;
        res = cur;
        for (int i = 0; i < NumStatusBits; i++) begin
            if (a_en && a_msk[i]) begin
                res[i] = a_val[i];
            end else if (d_en && d_msk[i]) begin
                res[i] = d_val[i];
            end else begin
                res[i] = cur[i];
            end
        end
        return res;
    endfunction

    // Decode the stack request; push and pop together cancel each other.
    always_comb begin
        w_op      = OP_NONE;
        w_push_ok = 1'b0;
        w_pop_ok  = 1'b0;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;
        w_op      = stack_op_e'({pop, push});
        case (w_op)
            OP_PUSH: begin
                w_push_ok = !w_full;
                w_ovf_evt = w_full;
            end
            OP_POP: begin
                w_pop_ok  = !w_empty;
                w_unf_evt = w_empty;
            end
            OP_NONE: begin
                w_push_ok = 1'b0;
            end
            OP_BOTH: begin
                w_push_ok = 1'b0;
            end
            default: begin
                w_push_ok = 1'b0;
            end
        endcase
    end

    assign w_merged = merge_status(r_status, alu_wr_en, alu_status, alu_mask,
                                   dec_wr_en, dec_status, dec_mask);

    status_lifo #(
        .Width  (NumStatusBits),
        .Depth  (StackDepth),
        .DepthW (DepthW)
    ) u_lifo (
        .clk     (clk),
        .res_n   (res_n),
        .push_en (w_push_ok),
        .pop_en  (w_pop_ok),
        .wr_data (r_status),
        .rd_data (w_top),
        .depth   (depth),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Status word and sticky error flags; a new error beats err_clr.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_status  <= STATUS_RST[NumStatusBits-1:0];
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_status <= w_top;
            end else begin
                r_status <= w_merged;
            end
            if (w_ovf_evt) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end else begin
                r_ovf_err <= r_ovf_err;
            end
            if (w_unf_evt) begin
                r_unf_err <= 1'b1;
            end else if (err_clr) begin
                r_unf_err <= 1'b0;
            end else begin
                r_unf_err <= r_unf_err;
            end
        end
    end

    assign status        = r_status;
    assign stack_full    = w_full;
    assign stack_empty   = w_empty;
    assign overflow_err  = r_ovf_err;
    assign underflow_err = r_unf_err;

endmodule

// File: tb/tb_status_stack_reg.sv
// Directed bench for status_stack_reg with hand-computed expectations.
module tb_status_stack_reg;

    logic       clk;
    logic       res_n;
    logic       alu_wr_en;
    logic [2:0] alu_status;
    logic [2:0] alu_mask;
    logic       dec_wr_en;
    logic [2:0] dec_status;
    logic [2:0] dec_mask;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [2:0] status;
    logic [2:0] depth;
    logic       stack_full;
    logic       stack_empty;
    logic       overflow_err;
    logic       underflow_err;

    int n_vec;
    int n_err;

    status_stack_reg #(
        .NumStatusBits (3),
        .StackDepth    (4)
    ) dut (
        .clk           (clk),
        .res_n         (res_n),
        .alu_wr_en     (alu_wr_en),
        .alu_status    (alu_status),
        .alu_mask      (alu_mask),
        .dec_wr_en     (dec_wr_en),
        .dec_status    (dec_status),
        .dec_mask      (dec_mask),
        .push          (push),
        .pop           (pop),
        .err_clr       (err_clr),
        .status        (status),
        .depth         (depth),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of requests, then return all inputs to idle.
    task automatic cyc(input logic a_en, input logic [2:0] a_st, input logic [2:0] a_m,
                       input logic d_en, input logic [2:0] d_st, input logic [2:0] d_m,
                       input logic psh, input logic pp, input logic clr);
        alu_wr_en = a_en; alu_status = a_st; alu_mask = a_m;
        dec_wr_en = d_en; dec_status = d_st; dec_mask = d_m;
        push = psh; pop = pp; err_clr = clr;
        @(posedge clk);
        #1;
        alu_wr_en = 1'b0; alu_status = 3'b000; alu_mask = 3'b000;
        dec_wr_en = 1'b0; dec_status = 3'b000; dec_mask = 3'b000;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        res_n = 1'b0;
        alu_wr_en = 1'b0; alu_status = 3'b000; alu_mask = 3'b000;
        dec_wr_en = 1'b0; dec_status = 3'b000; dec_mask = 3'b000;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        #12;
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_empty", 32'(stack_empty), 32'd1);
        chk("rst_full", 32'(stack_full), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        chk("rst_unf", 32'(underflow_err), 32'd0);
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU full-mask write
        cyc(1'b1, 3'b101, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("alu_wr", 32'(status), 32'd5);
        chk("alu_wr_empty", 32'(stack_empty), 32'd1);
        chk("alu_wr_depth", 32'(depth), 32'd0);

        // Clear, then simultaneous masked writes: bit0 ALU, bit1 dec, bit2 holds
        cyc(1'b1, 3'b000, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("clr_wr", 32'(status), 32'd0);
        cyc(1'b1, 3'b001, 3'b001, 1'b1, 3'b010, 3'b011, 1'b0, 1'b0, 1'b0);
        chk("merge_wr", 32'(status), 32'd3);
        cyc(1'b1, 3'b000, 3'b001, 1'b1, 3'b111, 3'b101, 1'b0, 1'b0, 1'b0);
        chk("merge_prio", 32'(status), 32'd6);

        // Fill: each push saves the pre-edge status while the write lands
        cyc(1'b1, 3'd1, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3'd2, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("push1_depth", 32'(depth), 32'd1);
        chk("push1_status", 32'(status), 32'd2);
        cyc(1'b1, 3'd3, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3'd4, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3'd5, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("full_depth", 32'(depth), 32'd4);
        chk("full_flag", 32'(stack_full), 32'd1);
        chk("full_ovf0", 32'(overflow_err), 32'd0);
        cyc(1'b1, 3'd6, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("ovf_depth", 32'(depth), 32'd4);
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_status", 32'(status), 32'd6);

        // Drain: restores 4,3,2,1 on consecutive cycles
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("pop4", 32'(status), 32'd4);
        chk("pop4_depth", 32'(depth), 32'd3);
        chk("pop4_full", 32'(stack_full), 32'd0);
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("pop3", 32'(status), 32'd3);
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("pop2", 32'(status), 32'd2);
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("pop1", 32'(status), 32'd1);
        chk("pop1_empty", 32'(stack_empty), 32'd1);
        chk("pop1_ovf_sticky", 32'(overflow_err), 32'd1);

        // Underflow with decoder write applied as if no pop
        cyc(1'b0, 3'b000, 3'b000, 1'b1, 3'b110, 3'b111, 1'b0, 1'b1, 1'b0);
        chk("unf_status", 32'(status), 32'd6);
        chk("unf_flag", 32'(underflow_err), 32'd1);
        chk("unf_depth", 32'(depth), 32'd0);
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        chk("clr_unf", 32'(underflow_err), 32'd0);
        chk("clr_ovf", 32'(overflow_err), 32'd0);
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1);
        chk("set_beats_clr", 32'(underflow_err), 32'd1);
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        chk("clr_again", 32'(underflow_err), 32'd0);

        // push&pop cancel at depth 2, then pop beats a concurrent write
        cyc(1'b1, 3'b001, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("pp_pre_depth", 32'(depth), 32'd2);
        cyc(1'b0, 3'b000, 3'b000, 1'b1, 3'b011, 3'b111, 1'b1, 1'b1, 1'b0);
        chk("pp_depth", 32'(depth), 32'd2);
        chk("pp_status", 32'(status), 32'd3);
        chk("pp_ovf", 32'(overflow_err), 32'd0);
        chk("pp_unf", 32'(underflow_err), 32'd0);
        cyc(1'b1, 3'b111, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("pop_vs_wr", 32'(status), 32'd1);
        chk("pop_vs_wr_depth", 32'(depth), 32'd1);
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("pop_base", 32'(status), 32'd6);
        chk("pop_base_empty", 32'(stack_empty), 32'd1);

        // Build depth 3 with both errors, then async reset
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_depth", 32'(depth), 32'd3);
        chk("pre_rst_ovf", 32'(overflow_err), 32'd1);
        chk("pre_rst_unf", 32'(underflow_err), 32'd1);
        chk("pre_rst_status", 32'(status), 32'd6);
        #2;
        res_n = 1'b0;
        #1;
        chk("arst_status", 32'(status), 32'd0);
        chk("arst_depth", 32'(depth), 32'd0);
        chk("arst_ovf", 32'(overflow_err), 32'd0);
        chk("arst_unf", 32'(underflow_err), 32'd0);
        chk("arst_empty", 32'(stack_empty), 32'd1);
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("post_rst_unf", 32'(underflow_err), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
